// File: rtl/video_multi_align.sv
// N-channel video aligner: per-channel FIFOs drained in lockstep so pixel k of every channel leaves on one DE.
// Build option: define VIDEO_MULTI_ALIGN_VS_INV_EN for active-low vin_vs (falling-edge frame start, inverted sync_vs).
module video_multi_align #(
  parameter int CH_NUM     = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                         sync_vclk,
  input  logic                         rst_n,
  input  logic [CH_NUM-1:0]            vin_vs,
  input  logic [CH_NUM-1:0]            vin_hs,
  input  logic [CH_NUM-1:0]            vin_de,
  input  logic [CH_NUM*DATA_WIDTH-1:0] vin_yc,
  output logic                         sync_vs,
  output logic                         sync_hs,
  output logic                         sync_de,
  output logic [CH_NUM*DATA_WIDTH-1:0] sync_yc,
  output logic                         aligned,
  output logic [CH_NUM-1:0]            ovf
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    ST_FLUSH = 2'd0,
    ST_ARM   = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic [CH_NUM-1:0]            vs_act, vs_act_q, fs;
  logic [CH_NUM-1:0]            armed_q, armed_d;
  logic [CH_NUM-1:0]            nonempty, full, wr_try, wr_en, ovf_evt, ovf_q;
  logic [CH_NUM*DATA_WIDTH-1:0] fifo_q, sync_yc_q;
  logic [1:0]                   vs_dly_q, hs_dly_q;
  logic                         rd, rd_q, sync_de_q, aligned_q, flush_next;
  logic                         unused_hs;

`ifdef VIDEO_MULTI_ALIGN_VS_INV_EN
  assign vs_act = ~vin_vs;
`else
  assign vs_act = vin_vs;
`endif

  assign fs        = vs_act & ~vs_act_q;
  assign wr_try    = vin_de & armed_q & {CH_NUM{state_q != ST_FLUSH}};
  assign ovf_evt   = wr_try & full;
  assign wr_en     = wr_try & ~full;
  assign rd        = (state_q == ST_RUN) && (&nonempty);
  assign unused_hs = ^vin_hs;

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    case (state_q)
      ST_FLUSH: begin
        armed_d = '0;
        state_d = ST_ARM;
      end
      ST_ARM: begin
        armed_d = armed_q | fs;
        if (&armed_q) state_d = ST_RUN;
      end
      ST_RUN: ;
      default: state_d = ST_FLUSH;
    endcase
    // Any dropped word breaks index alignment, so realign from the next frame starts.
    if (|ovf_evt) state_d = ST_FLUSH;
    flush_next = (state_d == ST_FLUSH);
  end

  always_ff @(posedge sync_vclk) begin
    if (!rst_n) begin
      state_q   <= ST_FLUSH;
      armed_q   <= '0;
      vs_act_q  <= '0;
      ovf_q     <= '0;
      rd_q      <= 1'b0;
      sync_de_q <= 1'b0;
      aligned_q <= 1'b0;
      vs_dly_q  <= '0;
      hs_dly_q  <= '0;
      sync_yc_q <= '0;
    end else begin
      state_q   <= state_d;
      armed_q   <= armed_d;
      vs_act_q  <= vs_act;
      ovf_q     <= ovf_q | ovf_evt;
      rd_q      <= rd && !flush_next;
      sync_de_q <= rd_q && !flush_next;
      aligned_q <= (state_d == ST_RUN);
      vs_dly_q  <= {vs_dly_q[0], vs_act[0]};
      hs_dly_q  <= {hs_dly_q[0], vin_hs[0]};
      if (rd_q) sync_yc_q <= fifo_q;
    end
  end

  for (genvar gi = 0; gi < CH_NUM; gi++) begin : g_ch
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic [DATA_WIDTH-1:0] q_q;

    assign nonempty[gi] = (count_q != '0);
    // Count never exceeds DEPTH, so its MSB alone marks a full FIFO.
    assign full[gi] = count_q[ADDR_WIDTH];
    assign fifo_q[gi*DATA_WIDTH +: DATA_WIDTH] = q_q;

    always_ff @(posedge sync_vclk) begin
      if (wr_en[gi]) mem[wr_ptr_q] <= vin_yc[gi*DATA_WIDTH +: DATA_WIDTH];
      if (rd) q_q <= mem[rd_ptr_q];
    end

    always_ff @(posedge sync_vclk) begin
      if (!rst_n || state_q == ST_FLUSH) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (wr_en[gi]) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
        if (rd) rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
        case ({wr_en[gi], rd})
          2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
          2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
          default: ;
        endcase
      end
    end
  end

  assign sync_vs = vs_dly_q[1];
  assign sync_hs = hs_dly_q[1];
  assign sync_de = sync_de_q;
  assign sync_yc = sync_yc_q;
  assign aligned = aligned_q;
  assign ovf     = ovf_q;
endmodule

// File: tb/tb_video_multi_align.sv
// Self-checking bench for video_multi_align: index-aligned scoreboard over randomized multi-channel frames.
`timescale 1ns/1ps
module tb_video_multi_align;
  localparam int CH   = 4;
  localparam int DW   = 16;
  localparam int AW   = 7;
  localparam int MAXW = 2048;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] vs_act, vin_vs, vin_hs, vin_de;
  logic [CH*DW-1:0] vin_yc;
  logic          sync_vs, sync_hs, sync_de, aligned;
  logic [CH*DW-1:0] sync_yc;
  logic [CH-1:0] ovf;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [CH*DW-1:0] obs_q [$];
  int               obs_t [$];
  logic [CH*DW-1:0] exp_q [$];
  logic             al_hist [0:65535];
  int               skew_a [CH];
  bit               vs_en [CH];
  int               nw_a [CH];
  bit               gaps;
  logic [DW-1:0]    wdata [CH][MAXW];
  int               first_de_cyc, frame_start;

  // Bench works in terms of the active vs level; the pin level depends on the build.
`ifdef VIDEO_MULTI_ALIGN_VS_INV_EN
  assign vin_vs = ~vs_act;
`else
  assign vin_vs = vs_act;
`endif

  video_multi_align #(.CH_NUM(CH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .sync_vclk(clk), .rst_n(rst_n),
    .vin_vs(vin_vs), .vin_hs(vin_hs), .vin_de(vin_de), .vin_yc(vin_yc),
    .sync_vs(sync_vs), .sync_hs(sync_hs), .sync_de(sync_de), .sync_yc(sync_yc),
    .aligned(aligned), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    al_hist[cyc[15:0]] = aligned;
    if (rst_n === 1'b1 && sync_de === 1'b1) begin
      obs_q.push_back(sync_yc);
      obs_t.push_back(cyc);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    rst_n = 1'b0; vs_act = '0; vin_hs = '0; vin_de = '0; vin_yc = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs_q.delete(); obs_t.delete(); exp_q.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      vin_de = '0; vs_act = '0; vin_hs = '0;
    end
  endtask

  // Model: the k-th output beat carries word k of every channel.
  function automatic void push_expected(input int n);
    logic [CH*DW-1:0] w;
    for (int k = 0; k < n; k++) begin
      for (int c = 0; c < CH; c++) w[c*DW +: DW] = wdata[c][k];
      exp_q.push_back(w);
    end
  endfunction

  task automatic drive_frame();
    int sent [CH];
    int max_skew;
    bit done;
    max_skew = 0;
    done = 1'b0;
    for (int c = 0; c < CH; c++) begin
      sent[c] = 0;
      if (vs_en[c] && skew_a[c] > max_skew) max_skew = skew_a[c];
    end
    first_de_cyc = -1;
    @(posedge clk); #1;
    frame_start = cyc;
    for (int t = 0; t < 6000 && !done; t++) begin
      if (t > 0) begin @(posedge clk); #1; end
      done = (t > max_skew + 2);
      for (int c = 0; c < CH; c++) begin
        vs_act[c] = vs_en[c] && (t == skew_a[c] || t == skew_a[c] + 1);
        vin_hs[c] = ((t % 50) < 3);
        vin_de[c] = 1'b0;
        vin_yc[c*DW +: DW] = DW'($urandom);
        if (t >= skew_a[c] + 3 && sent[c] < nw_a[c] && (!gaps || $urandom_range(0, 7) != 0)) begin
          vin_de[c] = 1'b1;
          vin_yc[c*DW +: DW] = wdata[c][sent[c]];
          sent[c]++;
          if (first_de_cyc < 0) first_de_cyc = cyc;
        end
        if (sent[c] < nw_a[c]) done = 1'b0;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL frame_timeout: still sending at cycle %0d, required completion within 6000 cycles", cyc);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      vs_act = CH'($urandom); vin_hs = CH'($urandom); vin_de = CH'($urandom);
      vin_yc = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if ({sync_vs, sync_hs, sync_de, aligned, ovf, sync_yc} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got vs=%b hs=%b de=%b al=%b ovf=%b yc=%h, required all 0",
                 sync_vs, sync_hs, sync_de, aligned, ovf, sync_yc);
      end
    end
    @(posedge clk); #1;
    rst_n = 1'b1; vs_act = '0; vin_hs = '0; vin_de = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({sync_de, aligned, ovf} !== '0) begin
        errors++;
        $display("FAIL reset_release: got de=%b al=%b ovf=%b, required 0", sync_de, aligned, ovf);
      end
    end
  endtask

  task automatic test_sync_delay();
    logic vh [40];
    logic hh [40];
    do_reset();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      vh[i] = 1'($urandom); hh[i] = 1'($urandom);
      vs_act[0] = vh[i]; vin_hs[0] = hh[i];
      @(negedge clk);
      if (i >= 2) begin
        checks++;
        if (sync_vs !== vh[i-2]) begin
          errors++;
          $display("FAIL sync_vs_delay: step %0d got %b, required %b", i, sync_vs, vh[i-2]);
        end
        checks++;
        if (sync_hs !== hh[i-2]) begin
          errors++;
          $display("FAIL sync_hs_delay: step %0d got %b, required %b", i, sync_hs, hh[i-2]);
        end
      end
    end
    idle(4);
  endtask

  task automatic test_zero_skew();
    do_reset();
    for (int c = 0; c < CH; c++) begin
      skew_a[c] = 0; vs_en[c] = 1'b1; nw_a[c] = 8;
      for (int k = 0; k < 8; k++) wdata[c][k] = DW'(c * 256 + k);
    end
    gaps = 1'b0;
    push_expected(8);
    drive_frame();
    idle(12);
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL zs_count: got %0d beats, required 8", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 8; k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL zs_data: beat %0d got %h, required %h", k, obs_q[k], exp_q[k]);
      end
      checks++;
      if (obs_t[k] != first_de_cyc + 3 + k) begin
        errors++;
        $display("FAIL zs_latency: beat %0d at cycle %0d, required %0d", k, obs_t[k], first_de_cyc + 3 + k);
      end
    end
    checks++;
    if (al_hist[16'(frame_start + 1)] !== 1'b0 || al_hist[16'(frame_start + 2)] !== 1'b1) begin
      errors++;
      $display("FAIL zs_aligned_rise: got %b,%b, required 0,1",
               al_hist[16'(frame_start + 1)], al_hist[16'(frame_start + 2)]);
    end
  endtask

  task automatic test_skew();
    do_reset();
    for (int c = 0; c < CH; c++) begin
      skew_a[c] = (c == 2) ? 37 : 0; vs_en[c] = 1'b1; nw_a[c] = 1920;
      for (int k = 0; k < 1920; k++) wdata[c][k] = DW'($urandom);
    end
    gaps = 1'b0;
    push_expected(1920);
    drive_frame();
    idle(12);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL skew_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL skew_data: beat %0d got %h, required %h", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (al_hist[16'(frame_start + 38)] !== 1'b0 || al_hist[16'(frame_start + 39)] !== 1'b1) begin
      errors++;
      $display("FAIL skew_aligned_rise: got %b,%b, required 0,1",
               al_hist[16'(frame_start + 38)], al_hist[16'(frame_start + 39)]);
    end
    checks++;
    if (ovf !== '0) begin
      errors++;
      $display("FAIL skew_ovf: got %b, required 0000", ovf);
    end
  endtask

  task automatic test_overflow();
    bit any_al;
    do_reset();
    for (int c = 0; c < CH; c++) begin
      skew_a[c] = 0; vs_en[c] = (c != 3); nw_a[c] = (c == 0) ? 129 : 0;
    end
    for (int k = 0; k < 129; k++) wdata[0][k] = DW'($urandom);
    gaps = 1'b0;
    drive_frame();
    idle(12);
    any_al = 1'b0;
    for (int i = frame_start; i <= cyc; i++) if (al_hist[16'(i)] === 1'b1) any_al = 1'b1;
    checks++;
    if (ovf !== 4'b0001) begin
      errors++;
      $display("FAIL ovf_flag: got %b, required 0001", ovf);
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL ovf_no_de: got %0d sync_de beats, required 0", obs_q.size());
    end
    checks++;
    if (any_al) begin
      errors++;
      $display("FAIL ovf_aligned: got aligned high during frame, required low");
    end
  endtask

  task automatic test_rearm();
    obs_q.delete(); obs_t.delete(); exp_q.delete();
    for (int c = 0; c < CH; c++) begin
      skew_a[c] = 0; vs_en[c] = 1'b1; nw_a[c] = 16;
      for (int k = 0; k < 16; k++) wdata[c][k] = DW'($urandom);
    end
    gaps = 1'b0;
    push_expected(16);
    drive_frame();
    idle(12);
    checks++;
    if (obs_q.size() != 16) begin
      errors++;
      $display("FAIL rearm_count: got %0d beats, required 16", obs_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < 16; k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL rearm_data: beat %0d got %h, required %h", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (ovf !== 4'b0001 || aligned !== 1'b1) begin
      errors++;
      $display("FAIL rearm_state: got ovf=%b aligned=%b, required ovf=0001 aligned=1", ovf, aligned);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    do_reset();
    for (int f = 0; f < 2; f++) begin
      n = $urandom_range(100, 300);
      for (int c = 0; c < CH; c++) begin
        skew_a[c] = $urandom_range(0, 40); vs_en[c] = 1'b1; nw_a[c] = n;
        for (int k = 0; k < n; k++) wdata[c][k] = DW'($urandom);
      end
      gaps = 1'b1;
      push_expected(n);
      drive_frame();
      idle(12);
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count: got %0d beats, required %0d", obs_q.size(), exp_q.size());
    end
    for (int k = 0; k < obs_q.size() && k < exp_q.size(); k++) begin
      checks++;
      if (obs_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL b2b_data: beat %0d got %h, required %h", k, obs_q[k], exp_q[k]);
      end
    end
    checks++;
    if (ovf !== '0) begin
      errors++;
      $display("FAIL b2b_ovf: got %b, required 0000", ovf);
    end
  endtask

  initial begin
    rst_n = 1'b0; vs_act = '0; vin_hs = '0; vin_de = '0; vin_yc = '0;
    test_reset();
    test_sync_delay();
    test_zero_skew();
    test_skew();
    test_overflow();
    test_rearm();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/video_multi_align.md
# video_multi_align

Single-clock, N-channel video stream aligner. Each channel gets its own FIFO; pixel data from all channels is released in lockstep on one shared DE, so downstream mixers see pixel k of every channel in the same cycle. It sits after the per-channel clock-domain resync stage, where all inputs already share `sync_vclk`, and before multi-window composition. It replaces ad-hoc per-channel resync plus manual skew trimming.

## Interface
Parameters:
- `CH_NUM`, 4: number of channels (1–8).
- `DATA_WIDTH`, 16: pixel word width per channel.
- `ADDR_WIDTH`, 7: FIFO address bits; depth = 2^ADDR_WIDTH words per channel.

Ports:
- `sync_vclk`  in  1: the only clock. One clock; reset is synchronous and active-low.
- `rst_n`  in  1: synchronous, active-low reset.
- `vin_vs`  in  CH_NUM: per-channel vertical sync.
- `vin_hs`  in  CH_NUM: per-channel horizontal sync.
- `vin_de`  in  CH_NUM: per-channel pixel valid.
- `vin_yc`  in  CH_NUM*DATA_WIDTH: channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `sync_vs`  out  1: aligned vertical sync (follows channel 0).
- `sync_hs`  out  1: aligned horizontal sync (follows channel 0).
- `sync_de`  out  1: common pixel valid for all channels.
- `sync_yc`  out  CH_NUM*DATA_WIDTH: aligned pixel words, same packing as `vin_yc`.
- `aligned`  out  1: high while in RUN.
- `ovf`  out  CH_NUM: sticky per-channel overflow flags; cleared only by reset.

## Operation
- **Frame-start event fs[i]:** leading (active) edge of `vin_vs[i]`, detected with one register stage per channel.
- **Per-channel FIFO:** registered read (data appears 1 cycle after the read request). Occupancy counter is ADDR_WIDTH+1 bits wide.
- **Write:** the FIFO writes when `vin_de[i]` is high AND `armed[i]` is set.
- **Simultaneous events:** a write and a read in the same cycle leave occupancy unchanged. A write into an empty FIFO becomes readable in the next cycle (no fall-through).
- **State machine (2 bits):**
  - FLUSH: all FIFO pointers and counters cleared, `armed` cleared. Lasts exactly 1 cycle, then goes to ARM.
  - ARM: fs[i] sets `armed[i]`. Once set, a channel writes and buffers while it waits for the others. When all `armed` bits are set, go to RUN.
  - RUN: global read `rd` = all FIFOs non-empty; every channel reads together when `rd` is high. Further fs events are ignored.
  - Overflow: a write attempt into a full FIFO (count = 2^ADDR_WIDTH) in ARM or RUN:
    - the word is dropped;
    - `ovf[i]` is set;
    - the state goes to FLUSH next cycle, which realigns at the next frame starts.
- **Skew tolerance:** inter-channel skew ≤ 2^ADDR_WIDTH − 1 pixels. Larger skew causes repeated overflow and realignment.
- **Output timing:**
  - `sync_vs` and `sync_hs` are channel 0's inputs delayed 2 registers. They are not skew-corrected, so downstream logic must key off `sync_de`.
  - `sync_de` is `rd` delayed 2 cycles; `sync_yc` is the FIFO q registered once.
- **Reset:** while `rst_n` = 0, all outputs are 0, `ovf` = 0 and the state is FLUSH. Asserting reset mid-frame discards all buffered data.

## Timing
- Latency from a `rd` cycle to the matching `sync_de` high is exactly 2 cycles.
- Once aligned, the minimum latency from the last channel's `vin_de` to `sync_de` is 3 cycles: write, then `rd`, then 2 cycles.
- Throughput is one word per channel per cycle, sustained. Reads stall only while some FIFO is empty.
- `aligned` is registered and rises the cycle after the last `armed` bit sets.
- Entering FLUSH drops `aligned` and forces `sync_de` to 0 from the next cycle. Any `rd` pipeline in flight is squashed.

## Configuration
- `VIDEO_MULTI_ALIGN_VS_INV_EN` defined:
  - all `vin_vs` inputs are treated as active-low, so fs is a falling edge;
  - `sync_vs` is driven active-high (inverted).
- Undefined: `vin_vs` is active-high (fs is a rising edge) and `sync_vs` passes through uninverted.

## Test plan
- **Reset:** hold `rst_n` = 0 for 5 cycles with random inputs -> all outputs 0; state FLUSH then ARM 2 cycles after release.
- **Zero skew:** CH_NUM=4; all channels start frame together, then each sends 8 words 0x0i00+k -> 8 consecutive `sync_de` cycles starting 3 cycles after the first `vin_de`; `sync_yc` shows word k of all four channels in the same cycle.
- **Skew:** channel 2 lags by 37 pixels, the others aligned -> `aligned` rises after ch2's fs; output words stay matched by index, with no loss or duplication over a 1920-pixel line.
- **Overflow:** ADDR_WIDTH=7; channel 3 never asserts vs while channel 0 sends 129 words -> `ovf[0]` = 1; FLUSH, then ARM; `sync_de` never asserted.
- **Re-arm:** after the overflow case, all channels start a frame together -> alignment recovers; `ovf[0]` stays 1.
- **Macro:** compile with `VIDEO_MULTI_ALIGN_VS_INV_EN`, drive active-low vs -> arming occurs on the falling edge; `sync_vs` equals the inverted ch0 vs delayed 2 cycles.
